// File: rtl/fifo_stream_reader_pkg.sv
// Shared defaults and helpers for the synch_fifo stream reader and its skid buffer.
package fifo_pkg;

   localparam int FIFO_PTR_DEF   = 3;
   localparam int FIFO_WIDTH_DEF = 16;
   localparam int BUF_DEPTH_DEF  = 2;
   localparam int BUF_PTR        = $clog2(BUF_DEPTH_DEF);
   localparam int CNT_WIDTH      = 32;

   // Pointer width for a buffer of the given depth (at least one bit).
   function automatic int ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/fifo_stream_reader_skid.sv
// DEPTH-entry register skid buffer: push at wr_ptr, pop at rd_ptr, head and valid straight from flops.
module fifo_reader_skid
   import fifo_pkg::*;
#(
   parameter  int WIDTH = FIFO_WIDTH_DEF,
   parameter  int DEPTH = BUF_DEPTH_DEF,
   localparam int PW    = ptr_w(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_i,
   output logic [PW:0]      cnt_o,
   output logic             valid_o,
   output logic [WIDTH-1:0] head_o
);

   logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
   logic [PW-1:0]               wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]               rd_ptr_q, rd_ptr_d;
   logic [PW:0]                 cnt_q, cnt_d;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push_i) begin
         mem_d[wr_ptr_q] = push_data_i;
         wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (pop_i) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      // Simultaneous push and pop leaves the occupancy unchanged.
      case ({push_i, pop_i})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   assign cnt_o   = cnt_q;
   assign valid_o = (cnt_q != '0);
   assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side master for synch_fifo: issues 1-cycle-latency reads and streams words out as valid/ready.
// Define FIFO_READER_CNT_EN to add the rd_count port counting words accepted downstream.
module fifo_stream_reader
   import fifo_pkg::*;
#(
   parameter int FIFO_PTR   = FIFO_PTR_DEF,
   parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
   parameter int BUF_DEPTH  = BUF_DEPTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic                  fifo_read_en,
   input  logic [FIFO_WIDTH-1:0] fifo_read_data,
   input  logic                  fifo_empty,
   output logic                  out_valid,
   output logic [FIFO_WIDTH-1:0] out_data,
   input  logic                  out_ready
`ifdef FIFO_READER_CNT_EN
   ,
   output logic [CNT_WIDTH-1:0]  rd_count
`endif
);

   localparam int PW = ptr_w(BUF_DEPTH);

   if (!(BUF_DEPTH == 2 || BUF_DEPTH == 4) || BUF_DEPTH > (1 << FIFO_PTR)) begin : g_bad_cfg
      $error("fifo_stream_reader: BUF_DEPTH must be 2 or 4 and no deeper than the FIFO");
   end

   logic          rd_pending_q, rd_pending_d;
   logic          pop;
   logic [PW:0]   buf_cnt;
   logic [PW+1:0] occ;

   assign pop = out_valid & out_ready;

   // Count the in-flight word as occupied so the buffer can never overflow;
   // crediting this cycle's pop lets a full buffer keep streaming at 1 word/cycle.
   always_comb begin
      occ          = (PW+2)'(buf_cnt) + (PW+2)'(rd_pending_q) - (PW+2)'(pop);
      fifo_read_en = rst_n & ~fifo_empty & (occ < (PW+2)'(BUF_DEPTH));
      rd_pending_d = fifo_read_en;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rd_pending_q <= 1'b0;
      else        rd_pending_q <= rd_pending_d;
   end

   fifo_reader_skid #(
      .WIDTH (FIFO_WIDTH),
      .DEPTH (BUF_DEPTH)
   ) u_skid (
      .clk         (clk),
      .rst_n       (rst_n),
      .push_i      (rd_pending_q),
      .push_data_i (fifo_read_data),
      .pop_i       (pop),
      .cnt_o       (buf_cnt),
      .valid_o     (out_valid),
      .head_o      (out_data)
   );

`ifdef FIFO_READER_CNT_EN
   logic [CNT_WIDTH-1:0] rd_count_q, rd_count_d;

   always_comb begin
      rd_count_d = rd_count_q;
      if (pop) rd_count_d = rd_count_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rd_count_q <= '0;
      else        rd_count_q <= rd_count_d;
   end

   assign rd_count = rd_count_q;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader against a behavioural 8-deep synch_fifo model, scoreboard checked.
module tb_fifo_stream_reader;

   localparam int BD = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wr_en;
   logic [15:0] wr_data;
   logic        fifo_read_en;
   logic [15:0] fifo_read_data;
   logic        fifo_empty;
   logic        out_valid;
   logic [15:0] out_data;
   logic        out_ready;
`ifdef FIFO_READER_CNT_EN
   logic [31:0] rd_count;
`endif

   int          vectors = 0;
   int          miscompares = 0;
   logic [15:0] sb[$];
   logic [15:0] fq[$];

   fifo_stream_reader #(
      .FIFO_PTR   (3),
      .FIFO_WIDTH (16),
      .BUF_DEPTH  (BD)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .fifo_read_en   (fifo_read_en),
      .fifo_read_data (fifo_read_data),
      .fifo_empty     (fifo_empty),
      .out_valid      (out_valid),
      .out_data       (out_data),
      .out_ready      (out_ready)
`ifdef FIFO_READER_CNT_EN
      ,
      .rd_count       (rd_count)
`endif
   );

   always #5 clk = ~clk;

   // synch_fifo model: read_data registered one cycle after read_en, full/empty from pre-edge state.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fq.delete();
         fifo_read_data <= '0;
         fifo_empty     <= 1'b1;
      end else begin
         int pre;
         pre = fq.size();
         if (fifo_read_en && pre != 0) fifo_read_data <= fq.pop_front();
         if (wr_en && pre < 8) fq.push_back(wr_data);
         fifo_empty <= (fq.size() == 0);
      end
   end

   task automatic do_reset();
      rst_n = 1'b0; wr_en = 1'b0; wr_data = '0; out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      sb.delete();
   endtask

   task automatic drive_write(input logic [15:0] d);
      wr_en = 1'b1; wr_data = d;
      if (fq.size() < 8) sb.push_back(d);
   endtask

   task automatic test_reset();
      logic [15:0] exp;
      rst_n = 1'b0; wr_en = 1'b0; wr_data = '0; out_ready = 1'b1;
      repeat (10) @(posedge clk);
      @(negedge clk);
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got=%b required=0", out_valid); end
      vectors++; if (out_data !== 16'h0) begin miscompares++; $display("FAIL reset_data got=%h required=0000", out_data); end
      vectors++; if (fifo_read_en !== 1'b0) begin miscompares++; $display("FAIL reset_read_en got=%b required=0", fifo_read_en); end
`ifdef FIFO_READER_CNT_EN
      vectors++; if (rd_count !== 32'd0) begin miscompares++; $display("FAIL reset_rd_count got=%0d required=0", rd_count); end
`endif
      @(posedge clk); #1 rst_n = 1'b1;
      sb.delete();
      exp = '0;
      @(negedge clk);
      vectors++; if (out_valid !== exp[0]) begin miscompares++; $display("FAIL post_reset_valid got=%b required=0", out_valid); end
      @(posedge clk); #1;
   endtask

   task automatic test_single();
      int n_rd = 0, rd_cyc = -1, n_vld = 0, vld_cyc = -1;
      logic [15:0] exp;
      do_reset();
      out_ready = 1'b1;
      drive_write(16'hA5A5);
      @(posedge clk); #1 wr_en = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (fifo_read_en) begin n_rd++; rd_cyc = k; end
         if (out_valid && out_ready) begin
            n_vld++; vld_cyc = k; vectors++;
            if (sb.size() == 0) begin miscompares++; $display("FAIL single_extra got=%h required=none", out_data); end
            else begin exp = sb.pop_front(); if (out_data !== exp) begin miscompares++; $display("FAIL single_data got=%h required=%h", out_data, exp); end end
         end
         @(posedge clk); #1;
      end
      vectors++; if (n_rd != 1) begin miscompares++; $display("FAIL single_read_pulses got=%0d required=1", n_rd); end
      vectors++; if (rd_cyc != 0) begin miscompares++; $display("FAIL single_read_cycle got=%0d required=0", rd_cyc); end
      vectors++; if (n_vld != 1) begin miscompares++; $display("FAIL single_valid_cycles got=%0d required=1", n_vld); end
      vectors++; if (vld_cyc != 2) begin miscompares++; $display("FAIL single_latency got=%0d required=2", vld_cyc); end
   endtask

   task automatic test_burst();
      int n_vld = 0, first = -1, last = -1;
      logic [15:0] exp;
      do_reset();
      out_ready = 1'b1;
      for (int k = 0; k < 20; k++) begin
         if (k < 8) drive_write(~16'(k + 1));
         else wr_en = 1'b0;
         @(negedge clk);
         if (out_valid && out_ready) begin
            n_vld++; if (first < 0) first = k; last = k; vectors++;
            if (sb.size() == 0) begin miscompares++; $display("FAIL burst_extra got=%h required=none", out_data); end
            else begin exp = sb.pop_front(); if (out_data !== exp) begin miscompares++; $display("FAIL burst_data got=%h required=%h", out_data, exp); end end
         end
         @(posedge clk); #1;
      end
      vectors++; if (n_vld != 8) begin miscompares++; $display("FAIL burst_count got=%0d required=8", n_vld); end
      vectors++; if (last - first != 7) begin miscompares++; $display("FAIL burst_gaps got_span=%0d required=7", last - first); end
      vectors++; if (sb.size() != 0) begin miscompares++; $display("FAIL burst_left got=%0d required=0", sb.size()); end
   endtask

   task automatic test_backpressure();
      int bad_stable = 0, bad_rd = 0, n_vld = 0;
      logic [15:0] exp;
      do_reset();
      out_ready = 1'b0;
      for (int k = 0; k < 8; k++) begin
         drive_write(16'h0100 + 16'(k));
         @(posedge clk); #1;
      end
      wr_en = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (out_valid !== 1'b1 || sb.size() == 0 || out_data !== sb[0]) bad_stable++;
         if (fifo_read_en !== 1'b0) bad_rd++;
         @(posedge clk); #1;
      end
      vectors++; if (bad_stable != 0) begin miscompares++; $display("FAIL bp_hold_stable got_bad=%0d required=0", bad_stable); end
      vectors++; if (bad_rd != 0) begin miscompares++; $display("FAIL bp_read_while_full got_bad=%0d required=0", bad_rd); end
      vectors++; if (fq.size() != 8 - BD) begin miscompares++; $display("FAIL bp_fifo_level got=%0d required=%0d", fq.size(), 8 - BD); end
      out_ready = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (out_valid && out_ready) begin
            n_vld++; vectors++;
            if (sb.size() == 0) begin miscompares++; $display("FAIL bp_extra got=%h required=none", out_data); end
            else begin exp = sb.pop_front(); if (out_data !== exp) begin miscompares++; $display("FAIL bp_data got=%h required=%h", out_data, exp); end end
         end
         @(posedge clk); #1;
      end
      vectors++; if (n_vld != 8) begin miscompares++; $display("FAIL bp_drain_count got=%0d required=8", n_vld); end
   endtask

   task automatic test_random();
      int sent = 0, got = 0, bad_rd = 0, cyc = 0;
      logic [15:0] exp;
      do_reset();
      while ((sent < 50 || sb.size() != 0) && cyc < 3000) begin
         if (sent < 50 && $urandom_range(0, 1) == 1) begin
            if (fq.size() < 8) sent++;
            drive_write(16'($urandom));
         end else wr_en = 1'b0;
         out_ready = ($urandom_range(0, 2) != 0);
         @(negedge clk);
         if (fifo_read_en && fifo_empty) bad_rd++;
         if (out_valid && out_ready) begin
            got++; vectors++;
            if (sb.size() == 0) begin miscompares++; $display("FAIL rand_extra got=%h required=none", out_data); end
            else begin exp = sb.pop_front(); if (out_data !== exp) begin miscompares++; $display("FAIL rand_data got=%h required=%h", out_data, exp); end end
         end
         @(posedge clk); #1;
         cyc++;
      end
      wr_en = 1'b0;
      vectors++; if (got != 50) begin miscompares++; $display("FAIL rand_delivered got=%0d required=50 (cycles=%0d)", got, cyc); end
      vectors++; if (bad_rd != 0) begin miscompares++; $display("FAIL rand_read_while_empty got=%0d required=0", bad_rd); end
`ifdef FIFO_READER_CNT_EN
      @(negedge clk);
      vectors++; if (rd_count !== 32'd50) begin miscompares++; $display("FAIL rand_rd_count got=%0d required=50", rd_count); end
      @(posedge clk); #1;
`endif
   endtask

   task automatic test_reset_mid();
      int n_vld = 0;
      logic [15:0] exp;
      do_reset();
      out_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         drive_write(16'h0BAD + 16'(k));
         @(posedge clk); #1;
      end
      wr_en = 1'b0;
      repeat (6) @(posedge clk);
      #1 rst_n = 1'b0;
      @(negedge clk);
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL mid_reset_valid got=%b required=0", out_valid); end
      vectors++; if (out_data !== 16'h0) begin miscompares++; $display("FAIL mid_reset_data got=%h required=0000", out_data); end
      vectors++; if (fifo_read_en !== 1'b0) begin miscompares++; $display("FAIL mid_reset_read_en got=%b required=0", fifo_read_en); end
      sb.delete();
      @(posedge clk); #1 rst_n = 1'b1;
      out_ready = 1'b1;
      drive_write(16'h1234);
      @(posedge clk); #1 wr_en = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (out_valid && out_ready) begin
            n_vld++; vectors++;
            if (sb.size() == 0) begin miscompares++; $display("FAIL mid_extra got=%h required=none", out_data); end
            else begin exp = sb.pop_front(); if (out_data !== exp) begin miscompares++; $display("FAIL mid_data got=%h required=%h", out_data, exp); end end
         end
         @(posedge clk); #1;
      end
      vectors++; if (n_vld != 1) begin miscompares++; $display("FAIL mid_post_count got=%0d required=1", n_vld); end
   endtask

   initial begin
      rst_n = 1'b0; wr_en = 1'b0; wr_data = '0; out_ready = 1'b0;
      test_reset();
      test_single();
      test_burst();
      test_backpressure();
      test_random();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
